// File: rtl/npu_mem_pkg.sv
// Shared definitions for the operand SRAM and its streaming read engine:
// memory geometry and the reader FSM state encoding.
package npu_mem_pkg;

    localparam int NPU_SRAM_ADDR_W = 12;
    localparam int NPU_SRAM_DATA_W = 16;
    localparam int NPU_SRAM_WORDS  = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } npu_rd_state_e;

endpackage

// File: rtl/npu_sram_stream_reader_if.sv
// Bundle of command, SRAM port-2 and output-stream signals of the stream reader.
// The engine uses the master modport; the environment (SRAM + consumer) uses slave.
interface npu_sram_stream_reader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;
    logic [ADDR_W-1:0] cmd_stride;

    logic [ADDR_W-1:0] sram_address;
    logic              sram_chipselect;
    logic              sram_write;
    logic [1:0]        sram_byteenable;
    logic              sram_clken;
    logic [DATA_W-1:0] sram_writedata;
    logic [DATA_W-1:0] sram_readdata;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_base, cmd_len, cmd_stride,
        output cmd_ready,
        output sram_address, sram_chipselect, sram_write, sram_byteenable,
        output sram_clken, sram_writedata,
        input  sram_readdata,
        output out_valid, out_data, out_last,
        input  out_ready,
        output busy, done
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_len, cmd_stride,
        input  cmd_ready,
        input  sram_address, sram_chipselect, sram_write, sram_byteenable,
        input  sram_clken, sram_writedata,
        output sram_readdata,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  busy, done
    );
endinterface

// File: rtl/npu_sync_fifo.sv
// Small first-word-fall-through FIFO with registered occupancy count.
// Head data reads as zero when empty so downstream outputs are clean after reset.
module npu_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_pop_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int                 PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]     CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]     DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full     = (r_count == DEPTH_C);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign w_push_ok  = i_push & ~o_full;
    assign w_pop_ok   = i_pop & ~o_empty;
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/npu_sram_stream_reader.sv
// Streaming read engine on SRAM port 2: walks base/stride/len, buffers the
// one-cycle-late read data in a small FIFO and presents it as a valid/ready stream.
module npu_sram_stream_reader
    import npu_mem_pkg::*;
#(
    parameter int ADDR_W     = NPU_SRAM_ADDR_W,
    parameter int DATA_W     = NPU_SRAM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    npu_sram_stream_reader_if.master bus
);
    localparam int                ENTRY_W = DATA_W + 1;
    localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);

    npu_rd_state_e     r_state;
    npu_rd_state_e     w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W:0]   r_remaining;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_zero_done;
    logic              r_armed;

    logic              w_cmd_ready;
    logic              w_accept;
    logic              w_issue;
    logic              w_drain_done;
    logic              w_pop;
    logic [CNT_W:0]    w_credit;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [ENTRY_W-1:0] w_fifo_head;

    // r_armed keeps cmd_ready low while reset is held and releases it one edge later.
    assign w_cmd_ready  = (r_state == ST_IDLE) & r_armed & ~r_zero_done;
    assign w_accept     = bus.cmd_valid & w_cmd_ready;
    // Credit uses only registered occupancy and inflight, never out_ready.
    assign w_credit     = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_issue      = (r_state == ST_RUN) & (r_remaining != '0)
                        & (w_credit < DEPTH_C) & ~w_fifo_full;
    assign w_drain_done = (r_state == ST_DRAIN) & w_fifo_empty & ~r_inflight;
    assign w_pop        = ~w_fifo_empty & bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (bus.cmd_len != '0)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_issue && (r_remaining == REM_ONE)) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr          <= '0;
            r_stride        <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_zero_done     <= 1'b0;
            r_armed         <= 1'b0;
        end else begin
            r_armed         <= 1'b1;
            r_zero_done     <= w_accept & (bus.cmd_len == '0);
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & (r_remaining == REM_ONE);
            if (w_accept) begin
                r_addr      <= bus.cmd_base;
                r_stride    <= bus.cmd_stride;
                r_remaining <= bus.cmd_len;
            end else if (w_issue) begin
                // Address wraps modulo the SRAM size by truncation.
                r_addr      <= r_addr + r_stride;
                r_remaining <= r_remaining - REM_ONE;
            end
        end
    end

    npu_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, bus.sram_readdata}),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_head),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign bus.cmd_ready       = w_cmd_ready;
    assign bus.sram_address    = r_addr;
    assign bus.sram_chipselect = w_issue;
    assign bus.sram_write      = 1'b0;
    assign bus.sram_byteenable = 2'b11;
    assign bus.sram_clken      = 1'b1;
    assign bus.sram_writedata  = '0;
    assign bus.out_valid       = ~w_fifo_empty;
    assign bus.out_data        = w_fifo_head[DATA_W-1:0];
    assign bus.out_last        = w_fifo_head[DATA_W];
    assign bus.busy            = (r_state != ST_IDLE);
    assign bus.done            = w_drain_done | r_zero_done;

endmodule

// File: tb/tb_npu_sram_stream_reader.sv
// Directed bench for npu_sram_stream_reader: SRAM model with mem[i]=i, stream
// monitor on the falling edge, immediate-assertion checks and one summary line.
module tb_npu_sram_stream_reader;
    import npu_mem_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    npu_sram_stream_reader_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    npu_sram_stream_reader #(
        .ADDR_W     (12),
        .DATA_W     (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // SRAM port-2 model: registered read, one cycle latency.
    logic [15:0] mem [4096];
    always @(posedge clk) begin
        if (bus.sram_chipselect && bus.sram_clken && !bus.sram_write) begin
            bus.sram_readdata <= mem[bus.sram_address];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: fixed level or a fixed ~50% stall pattern.
    logic        ready_lvl = 1'b1;
    logic        bp_mode   = 1'b0;
    logic        r_bp      = 1'b1;
    logic [31:0] bp_pat    = 32'hB38E_5A6D;
    always begin
        @(posedge clk);
        #1;
        r_bp = bp_pat[cyc[4:0]];
    end
    assign bus.out_ready = bp_mode ? r_bp : ready_lvl;

    // Monitor.
    logic [16:0] words [$];
    int          wcyc  [$];
    logic [11:0] addrs [$];
    int          dones [$];
    int          n_out       = 0;
    int          n_cs        = 0;
    int          n_done      = 0;
    int          credit_err  = 0;
    int          stall_err   = 0;
    int          rdybusy_err = 0;
    logic        prev_stall  = 1'b0;
    logic [16:0] prev_word   = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            n_out      <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (bus.sram_chipselect) begin
                if (n_out >= 4) credit_err <= credit_err + 1;
                addrs.push_back(bus.sram_address);
                n_cs <= n_cs + 1;
            end
            if (prev_stall && (!bus.out_valid || {bus.out_last, bus.out_data} != prev_word))
                stall_err <= stall_err + 1;
            if (bus.cmd_ready && bus.busy) rdybusy_err <= rdybusy_err + 1;
            if (bus.out_valid && bus.out_ready) begin
                words.push_back({bus.out_last, bus.out_data});
                wcyc.push_back(cyc);
                $display("[TB] word %04h last=%0b cycle %0d", bus.out_data, bus.out_last, cyc);
            end
            if (bus.done) begin
                dones.push_back(cyc);
                n_done <= n_done + 1;
            end
            n_out <= n_out + (bus.sram_chipselect ? 1 : 0) - ((bus.out_valid && bus.out_ready) ? 1 : 0);
            prev_stall <= bus.out_valid & ~bus.out_ready;
            prev_word  <= {bus.out_last, bus.out_data};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        words.delete();
        wcyc.delete();
        addrs.delete();
        dones.delete();
    endtask

    task automatic send_cmd(input logic [11:0] base, input logic [12:0] len,
                            input logic [11:0] stride, input bit hold, output int acc);
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_base   = base;
        bus.cmd_len    = len;
        bus.cmd_stride = stride;
        acc = -1;
        for (int t = 0; t < 400 && acc < 0; t++) begin
            if (bus.cmd_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (!hold) bus.cmd_valid = 1'b0;
        chk("cmd_accept", 32'(acc >= 0), 32'd1);
        $display("[TB] cmd base=%03h len=%0d stride=%0d accepted at %0d", base, len, stride, acc);
    endtask

    task automatic wait_done(input int target, input int bound);
        for (int t = 0; t < bound && n_done <= target; t++) begin
            @(posedge clk);
            #1;
        end
        chk("done_seen", 32'(n_done > target), 32'd1);
    endtask

    // Expected stream: address walks base+i*stride mod 4096, data = address.
    task automatic check_words(input string tag, input int off, input logic [11:0] base,
                               input int len, input logic [11:0] stride);
        logic [11:0] a;
        a = base;
        for (int i = 0; i < len; i++) begin
            if (off + i < words.size())
                chk({tag, "_data"}, 32'(words[off+i]), 32'({(i == len - 1), 4'h0, a}));
            if (off + i < addrs.size())
                chk({tag, "_addr"}, 32'(addrs[off+i]), 32'(a));
            a = a + stride;
        end
    endtask

    int acc, acc2, nd, ncs;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
        bus.cmd_valid  = 1'b0;
        bus.cmd_base   = '0;
        bus.cmd_len    = '0;
        bus.cmd_stride = '0;

        // Reset values.
        #3;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cs", 32'(bus.sram_chipselect), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Contiguous burst with exact timing.
        clear_logs();
        nd = n_done;
        send_cmd(12'h010, 13'd8, 12'd1, 1'b0, acc);
        wait_done(nd, 100);
        chk("c_count", 32'(words.size()), 32'd8);
        check_words("c", 0, 12'h010, 8, 12'd1);
        for (int i = 0; i < 8 && i < wcyc.size(); i++)
            chk("c_cycle", 32'(wcyc[i]), 32'(acc + 2 + i));
        if (dones.size() > 0 && wcyc.size() == 8)
            chk("c_done_cycle", 32'(dones[0]), 32'(wcyc[7] + 1));

        // Strided with address wrap.
        clear_logs();
        nd = n_done;
        send_cmd(12'hFFE, 13'd4, 12'd3, 1'b0, acc);
        wait_done(nd, 100);
        chk("w_count", 32'(words.size()), 32'd4);
        check_words("w", 0, 12'hFFE, 4, 12'd3);

        // Backpressure.
        clear_logs();
        nd = n_done;
        bp_mode = 1'b1;
        send_cmd(12'h200, 13'd16, 12'd1, 1'b0, acc);
        wait_done(nd, 400);
        bp_mode = 1'b0;
        chk("bp_count", 32'(words.size()), 32'd16);
        check_words("bp", 0, 12'h200, 16, 12'd1);
        chk("bp_credit_err", 32'(credit_err), 32'd0);
        chk("bp_stall_err", 32'(stall_err), 32'd0);

        // Zero length.
        clear_logs();
        nd = n_done;
        ncs = n_cs;
        send_cmd(12'h055, 13'd0, 12'd1, 1'b0, acc);
        wait_done(nd, 20);
        repeat (3) @(posedge clk);
        #1;
        if (dones.size() > 0) chk("z_done_cycle", 32'(dones[0]), 32'(acc));
        chk("z_done_pulses", 32'(dones.size()), 32'd1);
        chk("z_no_cs", 32'(n_cs - ncs), 32'd0);
        chk("z_no_words", 32'(words.size()), 32'd0);

        // Stride zero re-reads the same word.
        clear_logs();
        nd = n_done;
        send_cmd(12'h123, 13'd3, 12'd0, 1'b0, acc);
        wait_done(nd, 100);
        chk("s0_count", 32'(words.size()), 32'd3);
        check_words("s0", 0, 12'h123, 3, 12'd0);

        // Back-to-back with cmd_valid held high.
        clear_logs();
        nd = n_done;
        send_cmd(12'h300, 13'd4, 12'd1, 1'b1, acc);
        bus.cmd_base = 12'h400;
        bus.cmd_len  = 13'd2;
        send_cmd(12'h400, 13'd2, 12'd1, 1'b0, acc2);
        wait_done(nd + 1, 100);
        chk("bb_count", 32'(words.size()), 32'd6);
        check_words("bb_a", 0, 12'h300, 4, 12'd1);
        check_words("bb_b", 4, 12'h400, 2, 12'd1);
        if (dones.size() > 0) chk("bb_after_done", 32'(acc2 >= dones[0] + 2), 32'd1);
        chk("bb_ready_busy", 32'(rdybusy_err), 32'd0);

        // Reset mid-burst.
        clear_logs();
        send_cmd(12'h500, 13'd10, 12'd1, 1'b0, acc);
        for (int t = 0; t < 100 && words.size() < 5; t++) begin
            @(posedge clk);
            #1;
        end
        chk("mr_five_words", 32'(words.size()), 32'd5);
        reset_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_out_data", 32'(bus.out_data), 32'd0);
        chk("mr_out_last", 32'(bus.out_last), 32'd0);
        chk("mr_cs", 32'(bus.sram_chipselect), 32'd0);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        nd = n_done;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("mr_rel_empty", 32'(bus.out_valid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("mr_no_done", 32'(n_done), 32'(nd));
        clear_logs();
        send_cmd(12'h600, 13'd2, 12'd1, 1'b0, acc);
        wait_done(nd, 100);
        chk("mr_new_count", 32'(words.size()), 32'd2);
        check_words("mr_new", 0, 12'h600, 2, 12'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/npu_sram_stream_reader.md
# npu_sram_stream_reader

Streaming read engine that sits directly downstream of the 4096×16 dual-port on-chip operand SRAM and drives its second (s2) port. On a command (base address, length, stride) it issues word reads and presents the returned int16 operands to the NPU datapath as a valid/ready stream with a last marker. Bursts continue at one word per cycle under backpressure, with no data loss or duplication.

## Interface
Parameters:
- `ADDR_W`, 12, SRAM word-address width (4096 words)
- `DATA_W`, 16, SRAM/stream data width
- `FIFO_DEPTH`, 4, return-data buffer entries; power of two, ≥4

Ports:
- `clk`  in  1  single clock; also drives SRAM `clk2`
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  engine idle, can accept a command
- `cmd_base`  in  ADDR_W  first word address
- `cmd_len`  in  ADDR_W+1  word count, 0..4096
- `cmd_stride`  in  ADDR_W  address increment per word; 0 means re-read the same word
- `sram_address`  out  ADDR_W  to SRAM `address2`
- `sram_chipselect`  out  1  to `chipselect2`
- `sram_write`  out  1  tied 0
- `sram_byteenable`  out  2  tied 2'b11
- `sram_clken`  out  1  tied 1
- `sram_writedata`  out  DATA_W  tied 0
- `sram_readdata`  in  DATA_W  from `readdata2`
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  consumer accepts
- `out_data`  out  DATA_W  operand word
- `out_last`  out  1  final word of the command
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse when the last word is accepted, or when a zero-length command completes

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch base, stride and len into `addr` and `remaining`.
  - len=0 → pulse `done` next cycle and stay in IDLE.
  - Otherwise → RUN.
- RUN:
  - Issue condition: `remaining`>0 and `fifo_count + inflight < FIFO_DEPTH`.
  - On issue: `sram_chipselect`=1, `sram_address`=`addr`.
  - Next `addr` = (`addr` + `cmd_stride`) mod 2^ADDR_W; wrap from 4095 to 0 is legal and silent.
  - `remaining` decrements on each issue; when it reaches 0 → DRAIN.
- `inflight`:
  - 1-bit register, set on issue.
  - The next cycle, `sram_readdata` is pushed into the FIFO tagged `last` = (this was the final issue).
- DRAIN: when the FIFO is empty and `inflight`=0 → IDLE, with `done` pulsing that cycle.
- Stream output:
  - `out_data`/`out_last` come from the FIFO head; `out_valid` = FIFO non-empty.
  - Pop on `out_valid & out_ready`.
  - Data is held stable while `out_valid & ~out_ready`.
- The credit rule guarantees no FIFO overflow. A push and a pop in the same cycle leave the count unchanged.
- `busy` = state≠IDLE.
- Reset (async assert, sync deassert expected from the system):
  - All outputs 0 except `cmd_ready`=0 while `reset_n` is low; `cmd_ready`=1 in the first cycle after release.
  - FIFO flushed, `inflight` cleared, state → IDLE.
  - A reset mid-burst discards all pending words and produces no `done`.

## Timing
- Command handshake at edge k:
  - `sram_address`=base during cycle k→k+1.
  - `sram_readdata` valid in cycle k+1→k+2, pushed at edge k+2.
  - `out_valid`=1 from edge k+2.
- First-word latency is 2 cycles after the accept edge.
- With `out_ready` held at 1, throughput is 1 word/cycle with no bubbles (requires FIFO_DEPTH ≥ 4).
- There is no combinational path from `out_ready` to `sram_address`/`sram_chipselect`. Issue decisions use registered count and inflight only.
- `done` is asserted in the cycle after the pop of the `out_last` word.
- A new command is accepted no earlier than the cycle after `done`.

## Structure
- Shared package `npu_mem_pkg`: `NPU_SRAM_ADDR_W`=12, `NPU_SRAM_DATA_W`=16, `NPU_SRAM_WORDS`=4096, and the FSM state enum.
- One sub-module: `npu_sync_fifo` (parameterised width/depth, registered count, full/empty). Each entry stores {last, data}.
- The FSM, address generator and credit logic stay in the top module.

## Test plan
- Contiguous burst: SRAM preloaded mem[i]=i; cmd base=0x010, len=8, stride=1, `out_ready`=1 → words 0x0010..0x0017 on 8 consecutive cycles starting 2 cycles after accept; `out_last` on 0x0017; `done` 1 cycle later.
- Strided with wrap: base=0xFFE, len=4, stride=3 → addresses 0xFFE, 0x001, 0x004, 0x007 in that order; data matches.
- Backpressure: len=16, stride=1, `out_ready` random 50% → exactly 16 words, in order, no duplicates; chipselect never issued with `fifo_count + inflight` ≥ 4; `out_data` stable while stalled.
- Zero length / stride 0: len=0 → `done` pulse, no chipselect, no `out_valid`; len=3 stride=0 base=0x123 → three copies of mem[0x123].
- Back-to-back commands: `cmd_valid` held high with two commands → second accepted only after the first `done`; `cmd_ready`=0 while `busy`.
- Reset mid-burst: assert `reset_n`=0 after 5 of 10 words → outputs go to 0 immediately; after release, `cmd_ready`=1, FIFO empty, no `done` pulse; a new len=2 command completes correctly.
